// File: rtl/pq_pkg.sv
// Shared key-value type for the shift-register priority queue and its controller.
package pq_pkg;

  localparam int unsigned KEY_W = 8;
  localparam int unsigned VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  // Largest key marks an empty slot so it always sorts behind real entries.
  localparam kv_t KV_EMPTY = '{key: '1, val: '0};

endpackage

// File: rtl/sr_pq_ctrl_if.sv
// Requester-side push/pop/flush handshake of the priority-queue controller.
interface sr_pq_ctrl_if;

  logic          push_valid;
  logic          push_ready;
  pq_pkg::kv_t   push_kv;
  logic          pop_valid;
  logic          pop_ready;
  pq_pkg::kv_t   pop_kv;
  logic          pop_kv_valid;
  logic          flush;

  modport master (
    output push_valid, push_kv, pop_valid, flush,
    input  push_ready, pop_ready, pop_kv, pop_kv_valid
  );

  modport slave (
    input  push_valid, push_kv, pop_valid, flush,
    output push_ready, pop_ready, pop_kv, pop_kv_valid
  );

endinterface

// File: rtl/sr_pq_ctrl.sv
// Controller for a shift-register priority queue: push/pop handshake, min bypass,
// occupancy tracking and a flush sequencer that drains the array one entry per cycle.
module sr_pq_ctrl
  import pq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  sr_pq_ctrl_if.slave    req,
  output logic           pq_push,
  output logic           pq_pop,
  output kv_t            pq_kvi,
  input  kv_t            pq_head,
  output logic [CW-1:0]  count,
  output logic           full,
  output logic           empty,
  output logic           busy
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  kv_t           pop_kv_q, pop_kv_d;
  logic          pop_kv_valid_q, pop_kv_valid_d;

  logic push_acc, pop_acc, bypass;

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    busy  = (state_q == StFlush);

    pq_kvi         = req.push_kv;
    req.pop_ready  = 1'b0;
    req.push_ready = 1'b0;
    pq_push        = 1'b0;
    pq_pop         = 1'b0;
    push_acc       = 1'b0;
    pop_acc        = 1'b0;
    bypass         = 1'b0;
    state_d        = state_q;
    count_d        = count_q;
    pop_kv_d       = pop_kv_q;
    pop_kv_valid_d = 1'b0;

    unique case (state_q)
      StRun: begin
        req.pop_ready  = !empty && !req.flush;
        req.push_ready = !req.flush && (!full || (req.pop_valid && req.pop_ready));
        push_acc = req.push_valid && req.push_ready;
        pop_acc  = req.pop_valid && req.pop_ready;
        // A new key below the current head goes straight back out; the array is untouched.
        bypass   = push_acc && pop_acc && (req.push_kv.key < pq_head.key);
        pq_push  = push_acc && !bypass;
        pq_pop   = pop_acc && !bypass;

        if (push_acc && !pop_acc) begin
          count_d = count_q + CW'(1);
        end else if (pop_acc && !push_acc) begin
          count_d = count_q - CW'(1);
        end

        if (pop_acc) begin
          pop_kv_d       = bypass ? req.push_kv : pq_head;
          pop_kv_valid_d = 1'b1;
        end

        if (req.flush) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (!empty) begin
          pq_pop  = 1'b1;
          count_d = count_q - CW'(1);
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StRun;
      count_q        <= '0;
      pop_kv_q       <= KV_EMPTY;
      pop_kv_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      pop_kv_q       <= pop_kv_d;
      pop_kv_valid_q <= pop_kv_valid_d;
    end
  end

  assign count            = count_q;
  assign req.pop_kv       = pop_kv_q;
  assign req.pop_kv_valid = pop_kv_valid_q;

endmodule

// File: tb/tb_sr_pq_ctrl.sv
// Directed bench for sr_pq_ctrl: vector table plus flush and reset sequences,
// with a small behavioural priority-queue array driving pq_head.
module tb_sr_pq_ctrl;
  import pq_pkg::*;

  localparam int unsigned MD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pq_push, pq_pop;
  kv_t        pq_kvi, head;
  logic [3:0] count;
  logic       full, empty, busy;

  sr_pq_ctrl_if bus ();

  sr_pq_ctrl #(.DEPTH(MD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .pq_push (pq_push),
    .pq_pop  (pq_pop),
    .pq_kvi  (pq_kvi),
    .pq_head (head),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Behavioural array: unordered storage, head is the smallest key.
  kv_t mk [MD];
  int  mn;

  always_comb begin
    head = KV_EMPTY;
    for (int i = 0; i < int'(MD); i++) begin
      if (i < mn && mk[i].key < head.key) head = mk[i];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mn <= 0;
    end else begin
      automatic kv_t t [MD] = mk;
      automatic int  n = mn;
      automatic int  idx = 0;
      if (pq_pop && n > 0) begin
        for (int i = 1; i < n; i++) if (t[i].key < t[idx].key) idx = i;
        t[idx] = t[n-1];
        n--;
      end
      if (pq_push && n < int'(MD)) begin
        t[n] = pq_kvi;
        n++;
      end
      mk <= t;
      mn <= n;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       pv;
    logic [7:0] pk;
    logic       ov;
    logic       fl;
    logic       e_pr;
    logic       e_or;
    logic       e_qpush;
    logic       e_qpop;
    int         e_cnt;
    logic       e_v;
    logic [7:0] e_key;
  } vec_t;

  function automatic kv_t mkkv(input logic [7:0] k);
    return '{key: k, val: k ^ 8'h5a};
  endfunction

  // Called just after a rising edge; drives, checks combinational outputs, then the edge result.
  task automatic apply(input vec_t v, input string tag);
    bus.push_valid = v.pv;
    bus.push_kv    = mkkv(v.pk);
    bus.pop_valid  = v.ov;
    bus.flush      = v.fl;
    @(negedge clk);
    chk({tag, " push_ready"}, 32'(bus.push_ready), 32'(v.e_pr));
    chk({tag, " pop_ready"}, 32'(bus.pop_ready), 32'(v.e_or));
    chk({tag, " pq_push"}, 32'(pq_push), 32'(v.e_qpush));
    chk({tag, " pq_pop"}, 32'(pq_pop), 32'(v.e_qpop));
    chk({tag, " pq_kvi"}, 32'(pq_kvi), 32'(mkkv(v.pk)));
    @(posedge clk);
    #1;
    chk({tag, " count"}, 32'(count), 32'(v.e_cnt));
    chk({tag, " empty"}, 32'(empty), 32'(v.e_cnt == 0));
    chk({tag, " pop_kv_valid"}, 32'(bus.pop_kv_valid), 32'(v.e_v));
    if (v.e_v) chk({tag, " pop_kv"}, 32'(bus.pop_kv), 32'(mkkv(v.e_key)));
  endtask

  vec_t tbl [18];
  vec_t v;
  int   nb, np, nv;
  logic [3:0] pat;

  initial begin
    bus.push_valid = 1'b0;
    bus.push_kv    = '0;
    bus.pop_valid  = 1'b0;
    bus.flush      = 1'b0;

    //          pv pk  ov fl  pr or qpu qpo cnt v key
    tbl[0]  = '{1, 5,  1, 0,  1, 0, 1,  0,  1,  0, 0};  // empty: no pop
    tbl[1]  = '{0, 0,  1, 0,  1, 1, 0,  1,  0,  1, 5};
    tbl[2]  = '{1, 5,  0, 0,  1, 0, 1,  0,  1,  0, 0};
    tbl[3]  = '{1, 3,  0, 0,  1, 1, 1,  0,  2,  0, 0};
    tbl[4]  = '{1, 9,  0, 0,  1, 1, 1,  0,  3,  0, 0};
    tbl[5]  = '{0, 0,  1, 0,  1, 1, 0,  1,  2,  1, 3};
    tbl[6]  = '{0, 0,  1, 0,  1, 1, 0,  1,  1,  1, 5};
    tbl[7]  = '{0, 0,  1, 0,  1, 1, 0,  1,  0,  1, 9};
    tbl[8]  = '{1, 4,  0, 0,  1, 0, 1,  0,  1,  0, 0};
    tbl[9]  = '{1, 7,  0, 0,  1, 1, 1,  0,  2,  0, 0};
    tbl[10] = '{1, 2,  1, 0,  1, 1, 0,  0,  2,  1, 2};  // bypass
    tbl[11] = '{1, 6,  1, 0,  1, 1, 1,  1,  2,  1, 4};
    tbl[12] = '{0, 0,  0, 0,  1, 1, 0,  0,  2,  0, 0};
    tbl[13] = '{0, 0,  1, 0,  1, 1, 0,  1,  1,  1, 6};
    tbl[14] = '{0, 0,  1, 0,  1, 1, 0,  1,  0,  1, 7};
    tbl[15] = '{1, 3,  0, 0,  1, 0, 1,  0,  1,  0, 0};
    tbl[16] = '{1, 3,  1, 0,  1, 1, 1,  1,  1,  1, 3};  // equal key: no bypass
    tbl[17] = '{0, 0,  1, 0,  1, 1, 0,  1,  0,  1, 3};

    #12;
    chk("reset count", 32'(count), 0);
    chk("reset empty", 32'(empty), 1);
    chk("reset full", 32'(full), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset pop_kv_valid", 32'(bus.pop_kv_valid), 0);
    chk("reset pop_kv", 32'(bus.pop_kv), 32'(KV_EMPTY));
    chk("reset pq_push", 32'(pq_push), 0);
    chk("reset pq_pop", 32'(pq_pop), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Fill to capacity, then exercise the full boundary.
    for (int k = 0; k < 8; k++) begin
      v = '{1, 8'(10 + k), 0, 0, 1, k != 0, 1, 0, k + 1, 0, 0};
      apply(v, $sformatf("fill%0d", k));
    end
    chk("full flag", 32'(full), 1);
    apply('{1, 20, 0, 0, 0, 1, 0, 0, 8, 0, 0}, "full push held");
    apply('{1, 1,  1, 0, 1, 1, 0, 0, 8, 1, 1}, "full bypass");
    apply('{1, 20, 1, 0, 1, 1, 1, 1, 8, 1, 10}, "full swap");
    apply('{0, 0,  1, 0, 1, 1, 0, 1, 7, 1, 11}, "drain a");
    apply('{0, 0,  1, 0, 1, 1, 0, 1, 6, 1, 12}, "drain b");
    apply('{0, 0,  1, 0, 1, 1, 0, 1, 5, 1, 13}, "drain c");

    // Flush of 5 entries: 5 pop cycles plus one idle cycle.
    apply('{1, 2, 1, 1, 0, 0, 0, 0, 5, 0, 0}, "flush start");
    bus.flush = 1'b0; bus.push_valid = 1'b0; bus.pop_valid = 1'b0;
    nb = 0; np = 0; nv = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      nb += int'(busy); np += int'(pq_pop); nv += int'(bus.pop_kv_valid);
      @(posedge clk);
      #1;
    end
    chk("flush busy cycles", 32'(nb), 6);
    chk("flush pq_pop cycles", 32'(np), 5);
    chk("flush pop_kv_valid", 32'(nv), 0);
    chk("flush empty after", 32'(empty), 1);
    chk("flush busy after", 32'(busy), 0);

    // Flush of an empty queue holds busy exactly one cycle.
    apply('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0}, "flush empty");
    bus.flush = 1'b0;
    nb = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nb += int'(busy);
      @(posedge clk);
      #1;
    end
    chk("flush empty busy cycles", 32'(nb), 1);

    // Held flush is ignored in FLUSH but restarts it after returning to RUN.
    bus.flush = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pat[c] = busy;
      @(posedge clk);
      #1;
    end
    chk("held flush busy pattern", 32'(pat), 32'(4'b1010));
    bus.flush = 1'b0;
    @(negedge clk);
    chk("held flush released", 32'(busy), 0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a flush.
    apply('{1, 8, 0, 0, 1, 0, 1, 0, 1, 0, 0}, "pre-rst a");
    apply('{1, 6, 0, 0, 1, 1, 1, 0, 2, 0, 0}, "pre-rst b");
    apply('{1, 9, 0, 0, 1, 1, 1, 0, 3, 0, 0}, "pre-rst c");
    apply('{0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0}, "pre-rst flush");
    bus.flush = 1'b0;
    chk("mid flush busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst count", 32'(count), 0);
    chk("async rst busy", 32'(busy), 0);
    chk("async rst pop_kv_valid", 32'(bus.pop_kv_valid), 0);
    chk("async rst pq_pop", 32'(pq_pop), 0);
    chk("async rst pop_kv", 32'(bus.pop_kv), 32'(KV_EMPTY));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply('{1, 4, 0, 0, 1, 0, 1, 0, 1, 0, 0}, "post-rst push");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_pq_ctrl.md
SR_PQ_CTRL -- requirements
Module: sr_pq_ctrl

Interface
REQ-001 Parameter: DEPTH, default 8, number of entries in the shift-register priority-queue array being controlled.
REQ-002 Parameter: CW, default $clog2(DEPTH+1), occupancy count width.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 push_valid  in  1  requester offers a key-value for insertion.
REQ-007 push_ready  out  1  controller accepts push this cycle.
REQ-008 push_kv  in  kv_t  key-value to insert.
REQ-009 pop_valid  in  1  requester asks for the minimum entry.
REQ-010 pop_ready  out  1  controller accepts pop this cycle.
REQ-011 pop_kv  out  kv_t  registered pop result.
REQ-012 pop_kv_valid  out  1  one-cycle pulse qualifying pop_kv.
REQ-013 flush  in  1  request to drain the whole queue.
REQ-014 pq_push  out  1  push strobe to array.
REQ-015 pq_pop  out  1  pop strobe to array.
REQ-016 pq_kvi  out  kv_t  global key-value input to array.
REQ-017 pq_head  in  kv_t  current head (minimum) entry of array.
REQ-018 count  out  CW  current occupancy.
REQ-019 full, empty, busy  out  1 each  count==DEPTH, count==0, state==FLUSH.

Function
REQ-020 FSM SHALL have two states, RUN and FLUSH.
REQ-021 In RUN: pop_ready = !empty && !flush; push_ready = !flush && (!full || (pop_valid && pop_ready)).
REQ-022 Accept push = push_valid && push_ready; accept pop = pop_valid && pop_ready; both combinational in the same cycle.
REQ-023 pq_kvi SHALL equal push_kv combinationally.
REQ-024 Push only: pq_push=1, pq_pop=0, count+1 next edge.
REQ-025 Pop only: pq_pop=1, pq_push=0, count-1 next edge, pop_kv<=pq_head, pop_kv_valid=1 next cycle (latency 1).
REQ-026 Both accepted, push_kv.key >= pq_head.key: pq_push=pq_pop=1, pop_kv<=pq_head, count unchanged.
REQ-027 Both accepted, push_kv.key < pq_head.key (bypass): pq_push=pq_pop=0, pop_kv<=push_kv, pop_kv_valid pulses, count unchanged.
REQ-028 Full with push_valid and no pop accepted: push_ready=0, request held; no error, no count change.
REQ-029 Empty: pop_ready=0 even when push accepted in the same cycle; no bypass from empty.
REQ-030 flush=1 in RUN: no accepts that cycle; state->FLUSH next edge.
REQ-031 In FLUSH: push_ready=pop_ready=0; pq_pop=1 while count!=0, count-1 per cycle; pop_kv_valid stays 0 (entries discarded).
REQ-032 In FLUSH with count==0: pq_pop=0, state->RUN next edge; flush of an empty queue holds busy for exactly one cycle.
REQ-033 flush level while in FLUSH SHALL be ignored; after return to RUN a still-high flush restarts FLUSH.
REQ-034 count SHALL never exceed DEPTH nor go below 0.

Reset
REQ-035 On rst: state=RUN, count=0, pop_kv=KV_EMPTY, pop_kv_valid=0; combinational outputs follow (empty=1, full=0, busy=0, pq_push=pq_pop=0).
REQ-036 rst mid-FLUSH or mid-handshake SHALL abort immediately to reset values; the same rst also resets the array, so controller and array stay consistent.

Structure
REQ-037 kv_t and KV_EMPTY SHALL come from pq_pkg; the FSM state enum stays local to the module.
REQ-038 No sub-module; the stage array is instantiated beside the controller by the parent, connected only via pq_* ports.

Verification
REQ-039 Push keys 5,3,9 on consecutive cycles, then pop x3 -> pop_kv keys 3,5,9, each one cycle after accept; count 3->0.
REQ-040 Fill to DEPTH=8, assert push_valid alone -> push_ready=0, count stays 8; then push key 1 with pop -> push_ready=1, count stays 8.
REQ-041 Queue {4,7}, simultaneous push key 2 and pop -> bypass: pop_kv key 2, pq_push=pq_pop=0, count 2; repeat with push key 6 -> pop_kv key 4, both strobes high.
REQ-042 Queue with 5 entries, pulse flush -> busy 6 cycles (5 pops + 1), pq_pop high 5 cycles, no pop_kv_valid, then empty=1 and RUN.
REQ-043 Assert rst during FLUSH at count 3 -> count=0, busy=0, pop_kv_valid=0 immediately, asynchronously.
REQ-044 Empty queue, push key 5 and pop_valid same cycle -> pop_ready=0, push accepted, count 1, no pop_kv_valid.
